// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM DAC output stage
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int         PWM_WIDTH    = 8;
    localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - small synchronous sample FIFO with flush
// Ports: clk, nrst (async active-low); push/din write the tail, pop advances
// the head, dout shows the head entry; flush empties the FIFO on the next
// edge; full/empty reflect registered occupancy.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty when the
    // index bits are equal.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pwm_dac.sv
// rtl/pwm_dac.sv - single-bit PWM output stage with sample buffer and underrun tracking
// Ports: clk, nrst (async active-low), en (enable, low flushes/idles),
// tick (frame strobe), in_data/in_valid/in_ready (sample handshake),
// clr_underrun (clears underrun status), pwm (modulated output),
// frame_start (new duty active), underrun (sticky), underrun_cnt (saturating).
module pwm_dac
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             tick,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr_underrun,
    output logic             pwm,
    output logic             frame_start,
    output logic             underrun,
    output logic [7:0]       underrun_cnt
);

    state_t           state;
    logic [WIDTH-1:0] phase;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             underrun_evt;

    // in_ready is a function of registered state only, never of in_valid.
    assign in_ready = (state != IDLE) && !fifo_full;
    assign push     = in_valid && in_ready;
    // fifo_empty is registered, so a sample pushed on a tick cycle is not
    // visible to that tick's pop.
    assign pop          = en && tick && (state != IDLE) && !fifo_empty;
    assign underrun_evt = en && tick && (state == RUN) && fifo_empty;

    assign pwm = (state == RUN) && (phase < duty);

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .flush (!en),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            phase       <= '0;
            duty        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (!en) begin
                state <= IDLE;
                phase <= '0;
                duty  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                    end
                    ARMED: begin
                        if (pop) begin
                            duty        <= fifo_dout;
                            phase       <= '0;
                            state       <= RUN;
                            frame_start <= 1'b1;
                        end
                    end
                    RUN: begin
                        // Any tick resynchronises the frame, even on underrun.
                        phase <= tick ? '0 : phase + {{(WIDTH-1){1'b0}}, 1'b1};
                        if (pop) begin
                            duty        <= fifo_dout;
                            frame_start <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // A new underrun takes precedence over a simultaneous clear and restarts
    // the count at 1.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end else if (underrun_evt) begin
            underrun <= 1'b1;
            if (clr_underrun) begin
                underrun_cnt <= 8'd1;
            end else if (underrun_cnt != UNDERRUN_MAX) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
        end else if (clr_underrun) begin
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end
    end

endmodule

// File: doc/pwm_dac.md
# pwm_dac

Single-bit PWM output stage for the synth audio path. It consumes the one-cycle frame strobe produced by the 8-bit clock divider (one pulse every 256 clocks), buffers 8-bit samples from the sample generator through a valid/ready handshake, and plays one sample per frame as a duty cycle on `pwm`. Late samples are detected and counted as underruns.

## Interface
- `WIDTH`, default 8: sample width. The frame is 2^WIDTH clocks.
- `DEPTH`, default 2: sample buffer entries. Must be a power of 2 and at least 2.
- `clk`  in  1  system clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  block enable. Low flushes the block and idles it.
- `tick`  in  1  frame strobe from the divider. One-cycle pulse.
- `in_data`  in  WIDTH  sample value, used as the duty count.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a sample this cycle.
- `clr_underrun`  in  1  clears `underrun` and `underrun_cnt`.
- `pwm`  out  1  modulated output.
- `frame_start`  out  1  one-cycle pulse when a new duty becomes active.
- `underrun`  out  1  sticky flag: a frame started with no sample buffered.
- `underrun_cnt`  out  8  count of underruns, saturates at 255.

## Operation
- **States:** IDLE, ARMED, RUN.
- **IDLE.** Entered from reset, or from any state when `en`=0.
  - Next cycle: buffer flushed, phase=0, duty=0, `pwm`=0, `in_ready`=0.
- **IDLE to ARMED:** when `en`=1.
- **ARMED.** `in_ready` = !full.
  - `tick` with buffer non-empty: pop the head into duty, set phase to 0, go to RUN, pulse `frame_start`.
  - `tick` with buffer empty: stay in ARMED. This is not an underrun.
- **RUN.** phase increments every cycle and wraps 2^WIDTH-1 to 0. `pwm` = (phase < duty).
  - Every `tick` resets phase to 0 regardless of its current value, which resynchronises the frame.
  - `tick` with buffer non-empty: pop into duty and pulse `frame_start`.
  - `tick` with buffer empty: keep the previous duty, set `underrun`, increment `underrun_cnt` (saturating). No `frame_start` pulse.
- **Handshake.** A transfer happens when `in_valid` && `in_ready`. `in_ready` depends only on registered state and full; it has no combinational path from `in_valid`. Samples are popped in FIFO order.
- **Simultaneous push and pop:** both happen. Occupancy is unchanged.
- **Push into an empty buffer on a `tick` cycle:** no bypass. The pop sees the buffer as empty, so the underrun rule applies in RUN.
- **Duty edge values:** duty=0 gives `pwm` constantly 0. duty=2^WIDTH-1 gives `pwm` high for 255 of 256 cycles. Full scale is unreachable by design.
- **`clr_underrun` coinciding with a new underrun:** the new event wins. `underrun`=1, `underrun_cnt`=1.
- **`en` falling mid-frame:** buffered samples are discarded. `underrun` and `underrun_cnt` are kept; only reset or `clr_underrun` clears them.

## Timing
- **Reset values:** state=IDLE, `in_ready`=0, `pwm`=0, `frame_start`=0, `underrun`=0, `underrun_cnt`=0.
- **Enable:** `en` rising at cycle N gives `in_ready`=1 at cycle N+1.
- **Frame start:** `tick` at cycle T gives, at cycle T+1, duty updated, phase=0 and `frame_start`=1. `pwm` for slot 0 is also visible at T+1.
- **`pwm` source:** decoded from registered state, phase and duty only. There is no input-to-output combinational path.
- **`underrun` and `underrun_cnt`** update at T+1 of the offending `tick`.
- **Push to first use:** a sample accepted at cycle P is eligible for a `tick` at P+1 or later.

## Structure
- **Shared package `pwm_pkg`:** `state_t` enum (IDLE, ARMED, RUN), `PWM_WIDTH`=8, `UNDERRUN_MAX`=8'hFF.
- **Sub-module `sample_fifo`:** parameterised by WIDTH and DEPTH. Ports: push, pop, flush, din, dout, full, empty. Synchronous flush. Pointers carry one extra bit for full/empty detection.
- **Top level:** FSM, phase counter, duty register and underrun logic.

## Test plan
- **Basic frame:** reset, `en`=1, push 8'd64, `tick` every 256 cycles → `pwm` high exactly 64 cycles per frame, `frame_start` once per frame, `underrun`=0.
- **Extremes:** push 8'd0 then 8'd255 → first frame `pwm` constantly 0, second frame high 255 cycles and low 1.
- **Underrun:** push one sample of 8'd128, then give 3 `tick`s with no further push → duty stays 128, `underrun`=1, `underrun_cnt`=2. Then `clr_underrun` → both read 0.
- **Backpressure:** with DEPTH=2, hold `in_valid`=1 with values 10, 20, 30 → `in_ready` drops after 2 accepted. 30 is accepted only after the next `tick` pops 10. Frames play 10, 20, 30 in order.
- **Mid-operation abort:** deassert `en` at phase 100 with 2 samples buffered → `pwm`=0 and `in_ready`=0 next cycle. Re-enable plus `tick` with an empty buffer → stays ARMED, no underrun.
- **Resync and reset:** `tick` arriving early at phase 50 → phase=0 next cycle. Asserting `nrst` mid-frame → all outputs at their reset values immediately.
